// File: rtl/discharge_pulse_sequencer.sv
// EDM discharge pulse sequencer: times gate ON/OFF phases in units of CLK_PER_UNIT clocks and
// presents the shadowed peak-current setpoint and waveform code. Parameters latch only at pulse boundaries.
//
// state | meaning
// IDLE  | no pulse train; waits for is_machine with valid Ton/Toff
// ON    | gate driven, Ip_setpoint presented for shadow Ton units
// OFF   | gate released for shadow Toff units, then re-arm or stop
module discharge_pulse_sequencer #(
  parameter int CLK_PER_UNIT = 100,
  parameter int PRE_W        = 16
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        is_machine,
  input  logic [15:0] Ton_data,
  input  logic [15:0] Toff_data,
  input  logic [15:0] Ip_data,
  input  logic [15:0] waveform_data,
  output logic        pulse_on,
  output logic        pulse_start,
  output logic [15:0] Ip_setpoint,
  output logic [15:0] waveform_sel,
  output logic        busy,
  output logic        param_err,
  output logic [31:0] pulse_count
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_UNIT - 1);

  state_t           state, state_nx;
  logic [PRE_W-1:0] pre_cnt, pre_nx;
  logic [15:0]      unit_cnt, unit_nx;
  logic [15:0]      ton_sh, toff_sh, ip_sh;
  logic [15:0]      ton_sh_nx, toff_sh_nx, ip_sh_nx;
  logic [15:0]      target, ip_nx, wf_nx;
  logic [31:0]      count_q, count_nx;
  logic             params_ok, start_ok, pre_wrap, phase_end, load;
  logic             on_nx, start_nx, busy_nx, err_nx;

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    params_ok = (Ton_data != 16'd0) && (Toff_data != 16'd0);
    start_ok  = is_machine && params_ok;
    target    = (state == ON) ? ton_sh : toff_sh;
    pre_wrap  = (pre_cnt == PRE_LAST);
    // target is never 0 outside IDLE, so target-1 cannot underflow where it matters
    phase_end = pre_wrap && (unit_cnt == target - 16'd1);
    pre_nx    = pre_wrap ? '0 : pre_cnt + 1'b1;
    unit_nx   = pre_wrap ? unit_cnt + 16'd1 : unit_cnt;

    case (state)
      IDLE: begin
        pre_nx  = '0;
        unit_nx = '0;
        if (start_ok) begin
          state_nx = ON;
          load     = 1'b1;
        end
      end
      ON: begin
        if (phase_end) begin
          state_nx = OFF;
          pre_nx   = '0;
          unit_nx  = '0;
        end
      end
      OFF: begin
        if (phase_end) begin
          pre_nx  = '0;
          unit_nx = '0;
          if (start_ok) begin
            state_nx = ON;
            load     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        pre_nx   = '0;
        unit_nx  = '0;
      end
    endcase

    ton_sh_nx  = load ? Ton_data      : ton_sh;
    toff_sh_nx = load ? Toff_data     : toff_sh;
    ip_sh_nx   = load ? Ip_data       : ip_sh;
    wf_nx      = load ? waveform_data : waveform_sel;
    count_nx   = load ? count_q + 32'd1 : count_q;
    on_nx      = (state_nx == ON);
    start_nx   = load;
    busy_nx    = (state_nx != IDLE);
    err_nx     = (state_nx == IDLE) && is_machine && !params_ok;
    ip_nx      = on_nx ? ip_sh_nx : 16'd0;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      pre_cnt      <= '0;
      unit_cnt     <= '0;
      ton_sh       <= '0;
      toff_sh      <= '0;
      ip_sh        <= '0;
      count_q      <= '0;
      pulse_on     <= 1'b0;
      pulse_start  <= 1'b0;
      busy         <= 1'b0;
      param_err    <= 1'b0;
      Ip_setpoint  <= '0;
      waveform_sel <= '0;
    end else begin
      state        <= state_nx;
      pre_cnt      <= pre_nx;
      unit_cnt     <= unit_nx;
      ton_sh       <= ton_sh_nx;
      toff_sh      <= toff_sh_nx;
      ip_sh        <= ip_sh_nx;
      count_q      <= count_nx;
      pulse_on     <= on_nx;
      pulse_start  <= start_nx;
      busy         <= busy_nx;
      param_err    <= err_nx;
      Ip_setpoint  <= ip_nx;
      waveform_sel <= wf_nx;
    end
  end

  assign pulse_count = count_q;

endmodule

// File: tb/tb_discharge_pulse_sequencer.sv
// Bench for discharge_pulse_sequencer: directed scenarios plus random stimulus, every cycle
// compared against a phase/remaining-cycles reference model.
module tb_discharge_pulse_sequencer;
  localparam int CPU = 2;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        is_machine;
  logic [15:0] Ton_data, Toff_data, Ip_data, waveform_data;
  logic        pulse_on, pulse_start, busy, param_err;
  logic [15:0] Ip_setpoint, waveform_sel;
  logic [31:0] pulse_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model: phase 0=idle 1=on 2=off, m_left = cycles remaining in phase
  int          m_phase, m_left;
  logic [15:0] m_ton, m_toff, m_ip, m_wf;
  logic        m_start, m_perr;
  logic [31:0] m_cnt;

  discharge_pulse_sequencer #(.CLK_PER_UNIT(CPU), .PRE_W(16)) dut (
    .clk(clk), .sys_rst(sys_rst), .is_machine(is_machine),
    .Ton_data(Ton_data), .Toff_data(Toff_data), .Ip_data(Ip_data),
    .waveform_data(waveform_data), .pulse_on(pulse_on), .pulse_start(pulse_start),
    .Ip_setpoint(Ip_setpoint), .waveform_sel(waveform_sel), .busy(busy),
    .param_err(param_err), .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_start = 0; m_perr = 0;
    m_ton = '0; m_toff = '0; m_ip = '0; m_wf = '0; m_cnt = '0;
  endtask

  task automatic model_load();
    m_ton = Ton_data; m_toff = Toff_data; m_ip = Ip_data; m_wf = waveform_data;
    m_phase = 1;
    m_left  = int'(m_ton) * CPU;
    m_cnt   = m_cnt + 32'd1;
    m_start = 1;
  endtask

  task automatic model_step();
    logic ok;
    if (sys_rst) begin
      model_reset();
      return;
    end
    m_start = 0;
    ok = is_machine && (Ton_data != 0) && (Toff_data != 0);
    case (m_phase)
      0: if (ok) model_load();
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = 2;
          m_left  = int'(m_toff) * CPU;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (ok) model_load();
          else m_phase = 0;
        end
      end
    endcase
    m_perr = (m_phase == 0) && is_machine && ((Ton_data == 0) || (Toff_data == 0));
  endtask

  function automatic logic [67:0] dut_vec();
    return {pulse_on, pulse_start, Ip_setpoint, waveform_sel, busy, param_err, pulse_count};
  endfunction

  function automatic logic [67:0] exp_vec();
    return {m_phase == 1, m_start, (m_phase == 1) ? m_ip : 16'd0, m_wf,
            m_phase != 0, m_perr, m_cnt};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cycle", dut_vec(), exp_vec());
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_start();
    int k;
    k = 0;
    while (!pulse_start && k < 50) begin
      cycle();
      k++;
    end
    check("wait_start_timeout", pulse_start, 1'b1);
  endtask

  initial begin
    int hi;
    logic [31:0] saved;
    sys_rst = 1'b1; is_machine = 1'b0;
    Ton_data = '0; Toff_data = '0; Ip_data = '0; waveform_data = '0;
    model_reset();
    #12;
    check("reset", dut_vec(), 68'd0);
    @(negedge clk);
    sys_rst = 1'b0;

    // basic train
    Ton_data = 16'd3; Toff_data = 16'd2; Ip_data = 16'h0100; waveform_data = 16'd5;
    is_machine = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (pulse_on) hi++;
    end
    check("basic_on_cycles", hi, 6);
    cycles(10);
    check("basic_count", pulse_count, 2);
    check("basic_wf", waveform_sel, 16'd5);

    // mid-pulse update
    cycle();
    check("mid_start", pulse_start, 1'b1);
    Ton_data = 16'd1; Ip_data = 16'h0200;
    cycles(5);
    check("mid_still_on", {pulse_on, Ip_setpoint}, {1'b1, 16'h0100});
    cycles(5);
    check("mid_new_ip", {pulse_on, Ip_setpoint}, {1'b1, 16'h0200});
    cycle();
    check("mid_new_len", pulse_on, 1'b1);
    cycle();
    check("mid_new_end", pulse_on, 1'b0);

    // stop mid-ON
    Ton_data = 16'd3;
    wait_start();
    cycle();
    is_machine = 1'b0;
    saved = pulse_count;
    cycles(20);
    check("stop_busy", busy, 1'b0);
    check("stop_count", pulse_count, saved);

    // invalid params
    Toff_data = 16'd0; is_machine = 1'b1;
    cycles(3);
    check("inv_err", {param_err, pulse_on}, {1'b1, 1'b0});
    Toff_data = 16'd1;
    cycle();
    check("inv_recover", {param_err, pulse_on}, {1'b0, 1'b1});

    // async reset mid-ON
    cycle();
    #2 sys_rst = 1'b1;
    #1;
    check("async_rst", {pulse_on, pulse_count}, {1'b0, 32'd0});
    model_reset();
    @(negedge clk);
    sys_rst = 1'b0;
    cycle();
    check("rst_restart", {pulse_on, pulse_count}, {1'b1, 32'd1});

    // counter wrap
    is_machine = 1'b0;
    cycles(20);
    force dut.count_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    cycle();
    release dut.count_q;
    is_machine = 1'b1;
    cycle();
    check("wrap", pulse_count, 32'd0);

    // random stimulus
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) is_machine = ~is_machine;
      if ($urandom_range(0, 5) == 0) begin
        Ton_data      = 16'($urandom_range(1, 3));
        Toff_data     = 16'($urandom_range(1, 3));
        Ip_data       = 16'($urandom);
        waveform_data = 16'($urandom);
        if ($urandom_range(0, 7) == 0) Toff_data = 16'd0;
        if ($urandom_range(0, 7) == 0) Ton_data = 16'd0;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
